// File: rtl/datapath_sequencer_pkg.sv
// Shared definitions for the accumulator datapath controller and its ALU decoder.
package datapath_sequencer_pkg;

  localparam int ALU_OP_W = 4;
  localparam int INSTR_W  = 16;

  // Opcodes; the datapath ALU decodes the same values.
  localparam logic [ALU_OP_W-1:0] OP_NOP = 4'd0;
  localparam logic [ALU_OP_W-1:0] OP_ADD = 4'd1;
  localparam logic [ALU_OP_W-1:0] OP_SUB = 4'd2;
  localparam logic [ALU_OP_W-1:0] OP_AND = 4'd3;
  localparam logic [ALU_OP_W-1:0] OP_OR  = 4'd4;
  localparam logic [ALU_OP_W-1:0] OP_MUL = 4'd5;

  // Instruction field positions; bits [9:8] are reserved.
  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int FWDA_BIT = 11;
  localparam int FWDB_BIT = 10;
  localparam int CNT_MSB  = 7;
  localparam int CNT_LSB  = 0;
  localparam int CNT_FW   = CNT_MSB - CNT_LSB + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_EXEC = 3'd2,
    S_ITER = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  // Registered control word driven onto the datapath.
  typedef struct packed {
    logic                ready;
    logic                mux_a;
    logic                mux_b;
    logic                load_a;
    logic                load_b;
    logic                load_c;
    logic                clear_c;
    logic [ALU_OP_W-1:0] alu_op;
    logic                busy;
    logic                done;
    logic                error;
  } ctrl_t;

  function automatic logic op_legal(input logic [ALU_OP_W-1:0] op);
    return op <= OP_MUL;
  endfunction

endpackage

// File: rtl/datapath_sequencer_if.sv
// Instruction handshake and datapath control bundle.
interface datapath_sequencer_if
  import datapath_sequencer_pkg::*;
;
  logic                iInstrValid;
  logic [INSTR_W-1:0]  iInstr;
  logic                oReady;
  logic                oMuxASel;
  logic                oMuxBSel;
  logic                oLoadA;
  logic                oLoadB;
  logic                oLoadC;
  logic                oClearC;
  logic [ALU_OP_W-1:0] oAluOp;
  logic                oBusy;
  logic                oDone;
  logic                oError;

  modport master (
    output iInstrValid, iInstr,
    input  oReady, oMuxASel, oMuxBSel, oLoadA, oLoadB, oLoadC, oClearC,
           oAluOp, oBusy, oDone, oError
  );

  modport slave (
    input  iInstrValid, iInstr,
    output oReady, oMuxASel, oMuxBSel, oLoadA, oLoadB, oLoadC, oClearC,
           oAluOp, oBusy, oDone, oError
  );
endinterface

// File: rtl/datapath_sequencer_iter_counter.sv
// Multiply iteration down-counter; saturates at zero instead of wrapping.
module iter_counter #(
  parameter int CNTW = 8
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            load,
  input  logic            dec,
  input  logic [CNTW-1:0] load_val,
  output logic            oIsOne,
  output logic            oIsZero
);
  localparam logic [CNTW-1:0] ONE = CNTW'(1);

  logic [CNTW-1:0] cnt;

  // Load has priority over decrement; decrement stops at zero.
  always_ff @(posedge Clock) begin
    if (Reset)                   cnt <= '0;
    else if (load)               cnt <= load_val;
    else if (dec && cnt != '0)   cnt <= cnt - ONE;
  end

  assign oIsOne  = (cnt == ONE);
  assign oIsZero = (cnt == '0);
endmodule

// File: rtl/datapath_sequencer.sv
// Moore controller: load / execute / writeback sequencing, MUL as iterated ADD.
module datapath_sequencer
  import datapath_sequencer_pkg::*;
#(
  parameter int SIZE = 8,
  parameter int CNTW = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  datapath_sequencer_if.slave   bus
);
  // SIZE only documents the datapath this controller drives.
  if (SIZE < 1 || CNTW < CNT_FW) begin : g_bad_params
    $error("datapath_sequencer: SIZE must be >= 1 and CNTW must hold the count field");
  end

  state_t              state, state_nx;
  logic [ALU_OP_W-1:0] op, op_nx;
  logic                fwd_a, fwd_a_nx, fwd_b, fwd_b_nx;
  logic [CNT_FW-1:0]   cnt_f, cnt_f_nx;
  ctrl_t               ctrl;
  logic                cnt_is_one, cnt_is_zero;
  logic [ALU_OP_W-1:0] in_op;

  assign in_op = bus.iInstr[OPC_MSB:OPC_LSB];

  // Control word as a pure function of a state and the latched instruction.
  function automatic ctrl_t decode(input state_t s, input logic [ALU_OP_W-1:0] o,
                                   input logic fa, input logic fb);
    ctrl_t c;
    c = '0;
    c.busy = (s != S_IDLE);
    case (s)
      S_IDLE: c.ready = 1'b1;
      S_LOAD: begin
        c.load_a  = 1'b1;
        c.load_b  = 1'b1;
        c.mux_a   = fa;
        c.mux_b   = fb;
        c.clear_c = (o == OP_MUL);
      end
      S_EXEC: begin
        c.alu_op = o;
        c.load_c = 1'b1;
      end
      S_ITER: begin
        c.mux_a  = 1'b1;
        c.alu_op = OP_ADD;
        c.load_c = 1'b1;
      end
      S_DONE:  c.done  = 1'b1;
      S_ERR:   c.error = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next state and instruction latch; iInstr only matters on acceptance.
  always_comb begin
    state_nx = S_IDLE;
    op_nx    = op;
    fwd_a_nx = fwd_a;
    fwd_b_nx = fwd_b;
    cnt_f_nx = cnt_f;
    case (state)
      S_IDLE: begin
        state_nx = S_IDLE;
        if (bus.iInstrValid) begin
          op_nx    = in_op;
          fwd_a_nx = bus.iInstr[FWDA_BIT];
          fwd_b_nx = bus.iInstr[FWDB_BIT];
          cnt_f_nx = bus.iInstr[CNT_MSB:CNT_LSB];
          if (in_op == OP_NOP)      state_nx = S_DONE;
          else if (!op_legal(in_op)) state_nx = S_ERR;
          else                      state_nx = S_LOAD;
        end
      end
      S_LOAD:
        if (op == OP_MUL) state_nx = (cnt_f == '0) ? S_DONE : S_ITER;
        else              state_nx = S_EXEC;
      S_EXEC: state_nx = S_DONE;
      // Zero check is defensive: the counter never reaches it inside ITER.
      S_ITER: state_nx = (cnt_is_one || cnt_is_zero) ? S_DONE : S_ITER;
      default: state_nx = S_IDLE;
    endcase
  end

  // State, latched instruction and registered outputs advance together.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= S_IDLE;
      op    <= '0;
      fwd_a <= 1'b0;
      fwd_b <= 1'b0;
      cnt_f <= '0;
      ctrl  <= decode(S_IDLE, OP_NOP, 1'b0, 1'b0);
    end else begin
      state <= state_nx;
      op    <= op_nx;
      fwd_a <= fwd_a_nx;
      fwd_b <= fwd_b_nx;
      cnt_f <= cnt_f_nx;
      ctrl  <= decode(state_nx, op_nx, fwd_a_nx, fwd_b_nx);
    end
  end

  iter_counter #(.CNTW(CNTW)) u_cnt (
    .Clock    (Clock),
    .Reset    (Reset),
    .load     (state == S_LOAD && op == OP_MUL),
    .dec      (state == S_ITER),
    .load_val (CNTW'(cnt_f)),
    .oIsOne   (cnt_is_one),
    .oIsZero  (cnt_is_zero)
  );

  assign bus.oReady   = ctrl.ready;
  assign bus.oMuxASel = ctrl.mux_a;
  assign bus.oMuxBSel = ctrl.mux_b;
  assign bus.oLoadA   = ctrl.load_a;
  assign bus.oLoadB   = ctrl.load_b;
  assign bus.oLoadC   = ctrl.load_c;
  assign bus.oClearC  = ctrl.clear_c;
  assign bus.oAluOp   = ctrl.alu_op;
  assign bus.oBusy    = ctrl.busy;
  assign bus.oDone    = ctrl.done;
  assign bus.oError   = ctrl.error;
endmodule

// File: doc/datapath_sequencer.md
# datapath_sequencer

Multi-cycle Moore controller for the two-operand accumulator datapath: registers A and B, ALU, and result register C, with C fed back through the operand-A and operand-B 2:1 muxes. The block accepts one 16-bit instruction at a time over a valid/ready handshake. It sequences load, execute and writeback, drives the operand mux selects, register load enables and ALU opcode, and implements multiply as an iterated add on the existing ALU.

## Interface

Reset is synchronous, active-high; one clock.

Parameters:
- SIZE, 8, datapath width (carried for integration; the controller itself does not depend on it)
- CNTW, 8, iteration counter width

Ports:
- Clock  in  1  single clock; all state changes on its rising edge
- Reset  in  1  synchronous, active-high
- iInstrValid  in  1  instruction present on iInstr
- iInstr  in  16  [15:12] opcode, [11] fwdA, [10] fwdB, [9:8] reserved (ignored), [7:0] iteration count (MUL only)
- oReady  out  1  high only in IDLE; a transfer occurs when iInstrValid && oReady at an edge
- oMuxASel  out  1  1 = operand A mux selects C, 0 = external operand
- oMuxBSel  out  1  same for operand B
- oLoadA, oLoadB  out  1 each  register load enables
- oLoadC  out  1  result register load enable
- oClearC  out  1  synchronous clear of C
- oAluOp  out  4  ALU operation code
- oBusy  out  1  high in every state except IDLE
- oDone  out  1  one-cycle pulse on completion
- oError  out  1  one-cycle pulse on illegal opcode

## Operation

- Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 MUL; 6–15 are illegal.
- The instruction is latched on acceptance; iInstr is ignored at all other times.
- Outputs are decoded from the state register and the latched instruction only. There is no combinational input-to-output path.
- Default value of every output is 0.

States:
- IDLE
  - oReady=1.
  - On accept: NOP goes to DONE; illegal opcode goes to ERR; all others go to LOAD.
- LOAD
  - oLoadA=oLoadB=1.
  - oMuxASel=fwdA, oMuxBSel=fwdB.
  - For MUL: oClearC=1, and the counter loads the count field.
  - Next state: MUL with count 0 goes to DONE; MUL with count > 0 goes to ITER; all others go to EXEC.
- EXEC
  - oAluOp=opcode, oLoadC=1.
  - Next state: DONE.
- ITER
  - oMuxASel=1 (C), oMuxBSel=0 (B register path), oAluOp=ADD(1), oLoadC=1.
  - The counter decrements each cycle.
  - Leaves for DONE after the cycle in which the counter equals 1.
- DONE
  - oDone=1.
  - Next state: IDLE.
- ERR
  - oError=1.
  - Next state: IDLE.

Additional rules:
- Unreachable state encodings go to IDLE.
- Reserved bits [9:8] have no effect.
- Forward bits are honoured for every opcode except NOP.

## Timing

Cycle numbering: acceptance is at edge 0; cycle k is the cycle after edge k.
- ADD/SUB/AND/OR: LOAD in cycle 1, EXEC in cycle 2, oDone in cycle 3, oReady in cycle 4. Issue interval is 4 cycles.
- MUL with count N ≥ 1: LOAD in cycle 1, ITER in cycles 2..N+1, oDone in cycle N+2, oReady in cycle N+3.
- MUL with N = 0: oDone in cycle 2, and C has been cleared.
- NOP: oDone in cycle 1.
- Illegal opcode: oError in cycle 1; nothing else asserted.
- Count 255 gives exactly 255 ITER cycles. The counter never wraps below 0.
- iInstrValid held high during busy states produces no transfer. A new instruction is accepted in the first IDLE cycle. Back-to-back transfers are never possible.
- Reset, including mid-operation:
  - Takes effect at the next edge regardless of state or inputs; it overrides any transfer at that edge.
  - State returns to IDLE; the counter and latched instruction clear to 0.
  - Output values after reset: oReady=1, all other outputs 0.
  - No oDone or oError pulse is produced for an aborted instruction.

## Structure

- Shared package holds:
  - opcode constants
  - instruction field positions (opcode, fwdA, fwdB, count)
  - state encoding
  - the ALU opcode width
- The datapath ALU decoder uses the same opcode constants.
- One sub-module, iter_counter:
  - CNTW-bit down-counter with synchronous load, decrement enable and Reset
  - outputs oIsOne and oIsZero
- Everything else (FSM, instruction latch, output decode) lives in datapath_sequencer.

## Test plan

1. Reset: assert Reset for 2 cycles with iInstrValid=1 and iInstr=0x1000 -> oReady=1, all other outputs 0, no acceptance.
2. ADD with fwdA (0x1800) -> LOAD: oMuxASel=1, oMuxBSel=0, oLoadA=oLoadB=1; EXEC: oAluOp=1, oLoadC=1; oDone in cycle 3; oReady in cycle 4.
3. MUL count 3 (0x5003) -> oClearC in cycle 1; ITER cycles 2–4 each with oAluOp=1, oMuxASel=1, oLoadC=1; oDone in cycle 5. Also MUL 0x5000 -> oDone in cycle 2 with no oLoadC.
4. Illegal 0x7000 -> oError pulse in cycle 1 only; oReady in cycle 2. Also NOP 0x0000 -> oDone in cycle 1.
5. Reset in cycle 3 of MUL count 10 -> IDLE next cycle, no oDone; a new SUB 0x2000 then completes with oDone 3 cycles after acceptance.
6. iInstrValid held high with alternating instructions during busy -> exactly one transfer per IDLE cycle; instruction latched equals iInstr at that edge.
